// File: rtl/dmac_bi_scaled_param_if.sv
// rtl/dmac_bi_scaled_param_if.sv - handshake/data bundle for the bipolar scaled product-sum engine
// Purpose: groups the run control, operand and result signals of dmac_bi_scaled_param.
// Ports (signals):
//   start, en          run request / run enable            (master -> slave)
//   iA, iB             N channels of W-bit offset-binary    (master -> slave)
//   busy, oC, oValid   status and output bitstream          (slave -> master)
//   oCount             ones count of the last completed run (slave -> master)
//   done               one-cycle run completion pulse       (slave -> master)
interface dmac_bi_scaled_param_if #(
  parameter int N = 16,
  parameter int W = 8
);
  logic                  start;
  logic                  en;
  logic [N-1:0][W-1:0]   iA;
  logic [N-1:0][W-1:0]   iB;
  logic                  busy;
  logic                  oC;
  logic                  oValid;
  logic [2*W:0]          oCount;
  logic                  done;

  modport master (
    output start, en, iA, iB,
    input  busy, oC, oValid, oCount, done
  );

  modport slave (
    input  start, en, iA, iB,
    output busy, oC, oValid, oCount, done
  );
endinterface

// File: rtl/dmac_bi_scaled_param.sv
// rtl/dmac_bi_scaled_param.sv - stochastic bipolar multiply and scaled add over N channels
// Purpose: on start, captures N operand pairs, then streams L = 2^(2W) bits whose ones
// density encodes (1/N) * sum of the bipolar channel products, and reports the ones count.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   dmac_bi_scaled_param_if.slave (start/en/iA/iB in; busy/oC/oValid/oCount/done out)
module dmac_bi_scaled_param #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  dmac_bi_scaled_param_if.slave    bus
);

  localparam int LOGN = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0][W-1:0] op_a_q, op_a_d;
  logic [N-1:0][W-1:0] op_b_q, op_b_d;
  logic [W-1:0]        cnt_a_q, cnt_a_d;
  logic [W-1:0]        cnt_b_q, cnt_b_d;
  logic [2*W:0]        acc_q, acc_d;
  logic [2*W:0]        count_q, count_d;
  logic                oc_q, oc_d;
  logic                ovalid_q, ovalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [W-1:0]        rng_a;
  logic [W-1:0]        rng_b;
  logic [LOGN-1:0]     sel_x;
  logic [LOGN-1:0]     sel;
  logic                m_bit;

  // Van der Corput sources and the channel selector for the scaled add.
  always_comb begin
    rng_a = '0;
    rng_b = '0;
    sel   = '0;
    for (int i = 0; i < W; i++) begin
      rng_a[i] = cnt_a_q[W-1-i];
      rng_b[i] = cnt_b_q[W-1-i];
    end
    sel_x = cnt_a_q[LOGN-1:0] ^ cnt_b_q[LOGN-1:0];
    for (int i = 0; i < LOGN; i++) begin
      sel[i] = sel_x[LOGN-1-i];
    end
    // Only the selected channel's product is needed, so compare just that one.
    m_bit = ~((op_a_q[sel] > rng_a) ^ (op_b_q[sel] > rng_b));
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    acc_d    = acc_q;
    count_d  = count_q;
    oc_d     = oc_q;
    ovalid_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        op_a_d  = bus.iA;
        op_b_d  = bus.iB;
        cnt_a_d = '0;
        cnt_b_d = '0;
        acc_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.en) begin
          oc_d     = m_bit;
          ovalid_d = 1'b1;
          // Counting at generation time keeps the final bit inside acc by DONE.
          acc_d    = acc_q + {{(2*W){1'b0}}, m_bit};
          cnt_a_d  = cnt_a_q + {{(W-1){1'b0}}, 1'b1};
          if (&cnt_a_q) cnt_b_d = cnt_b_q + {{(W-1){1'b0}}, 1'b1};
          if ((&cnt_a_q) && (&cnt_b_q)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        count_d = acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      oc_q     <= 1'b0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      oc_q     <= oc_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.oC     = oc_q;
  assign bus.oValid = ovalid_q;
  assign bus.oCount = count_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_dmac_bi_scaled_param.sv
// tb/tb_dmac_bi_scaled_param.sv - scoreboard bench for dmac_bi_scaled_param
module tb_dmac_bi_scaled_param;
  localparam int N = 4;
  localparam int W = 4;
  localparam int L = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmac_bi_scaled_param_if #(.N(N), .W(W)) bus ();
  dmac_bi_scaled_param #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests_run = 0;
  int tests_failed = 0;
  bit exp_bits[$];
  int exp_cnt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // Reference: walk the L counter states directly as (k mod 16, k div 16).
  function automatic int model(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b);
    int ones = 0;
    for (int k = 0; k < L; k++) begin
      logic [3:0] ca, cb, x;
      logic [1:0] s;
      bit m;
      ca = 4'(k % 16);
      cb = 4'(k / 16);
      x  = ca ^ cb;
      s  = {x[0], x[1]};
      m  = ((a[s] > rev4(ca)) == (b[s] > rev4(cb)));
      exp_bits.push_back(m);
      ones += int'(m);
    end
    return ones;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.oValid) begin
        if (exp_bits.size() == 0) fail_now("unexpected_oValid");
        else check("oC_bit", {31'd0, bus.oC}, {31'd0, exp_bits.pop_front()});
      end
      if (bus.done) begin
        if (exp_cnt.size() == 0) fail_now("unexpected_done");
        else check("oCount_sb", {22'd0, bus.oCount}, exp_cnt.pop_front());
      end
    end
  end

  // mode: toggle_en stalls every other RUN cycle; perturb re-pulses start/changes iA
  // mid-run and pulses start in the DONE cycle; abort_at>0 resets at that edge.
  task automatic run(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b,
                     input bit toggle_en, input bit perturb, input int abort_at,
                     output int ones);
    int edges, enabled, stalls, done_edge, seen;
    ones = model(a, b);
    exp_cnt.push_back(ones);
    @(posedge clk); #2;
    bus.iA = a; bus.iB = b; bus.start = 1'b1; bus.en = 1'b1;
    edges = -1; enabled = 0; stalls = 0; done_edge = -1;
    while (done_edge < 0 && edges < 2000) begin
      @(posedge clk); #2;
      edges++;
      if (edges >= 2 && enabled < L) begin
        if (bus.en) enabled++; else stalls++;
      end
      if (bus.done) done_edge = edges;
      bus.start = 1'b0;
      if (abort_at > 0 && edges == abort_at) begin
        rst = 1'b1;
        exp_bits.delete();
        exp_cnt.delete();
        #1;
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_oValid", {31'd0, bus.oValid}, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        seen = 0;
        repeat (300) begin
          @(posedge clk); #2;
          if (bus.done) seen++;
        end
        check("abort_no_done", seen, 0);
        return;
      end
      bus.en = (toggle_en && enabled < L) ? ~bus.en : 1'b1;
      if (perturb && edges >= 5 && edges < 200 && edges % 23 == 0) begin
        bus.start = 1'b1;
        bus.iA = 16'($urandom);
      end
      if (perturb && enabled == L && done_edge < 0) bus.start = 1'b1;
    end
    check("done_edge", done_edge, L + 2 + stalls);
    if (perturb) begin
      @(posedge clk); #2;
      check("start_in_done_ignored", {31'd0, bus.busy}, 0);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    logic [N-1:0][W-1:0] ra, rb;
    int ones, ref_ones, ignore;
    real sum, ideal, diff;
    rst = 1'b1;
    bus.start = 1'b0; bus.en = 1'b0; bus.iA = '0; bus.iB = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_oC", {31'd0, bus.oC}, 0);
    check("rst_oValid", {31'd0, bus.oValid}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_oCount", {22'd0, bus.oCount}, 0);
    rst = 1'b0;

    run('0, '0, 0, 0, 0, ones);
    check("zero_oCount", {22'd0, bus.oCount}, 256);
    repeat (5) @(posedge clk);
    #2;
    check("oCount_hold", {22'd0, bus.oCount}, 256);

    run('0, {4'd8, 4'd8, 4'd8, 4'd8}, 0, 0, 0, ones);
    check("bipolar0_oCount", {22'd0, bus.oCount}, 128);

    ra = {4'd15, 4'd15, 4'd0, 4'd0};
    rb = {4'd15, 4'd0, 4'd15, 4'd0};
    run(ra, rb, 0, 0, 0, ones);
    sum = 0.0;
    for (int i = 0; i < N; i++)
      sum += (2.0 * ra[i] / 16.0 - 1.0) * (2.0 * rb[i] / 16.0 - 1.0);
    ideal = L * (1.0 + sum / N) / 2.0;
    diff = real'(bus.oCount) - ideal;
    if (diff < 0.0) diff = -diff;
    check("mixed_tolerance", {31'd0, diff <= 8.0}, 1);

    ra = 16'($urandom);
    rb = 16'($urandom);
    run(ra, rb, 0, 0, 0, ref_ones);
    ones = int'(bus.oCount);
    run(ra, rb, 1, 0, 0, ignore);
    check("stalled_vs_plain", {22'd0, bus.oCount}, ones);
    run(ra, rb, 0, 1, 0, ignore);
    check("perturbed_vs_plain", {22'd0, bus.oCount}, ones);
    run(ra, rb, 0, 0, 102, ignore);
    run(ra, rb, 0, 0, 0, ignore);
    check("after_abort_vs_plain", {22'd0, bus.oCount}, ones);

    for (int t = 0; t < 3; t++) begin
      run(16'($urandom), 16'($urandom), t[0], 0, 0, ignore);
    end

    repeat (3) @(posedge clk);
    #2;
    check("bits_drained", exp_bits.size(), 0);
    check("counts_drained", exp_cnt.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
